// File: rtl/overcurrent_guard.sv
// Multi-channel overcurrent guard: per-channel PWM blanking, debounced trip with timed
// auto-retry and lockout, plus a debounced battery lockout that gates every channel.
module overcurrent_guard #(
    parameter int unsigned NCH          = 2,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned RETRY_CYCLES = 1000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   pwm,
    input  logic [NCH-1:0]   over_ch,
    input  logic             over_bat,
    input  logic             clear,
    output logic [NCH-1:0]   en,
    output logic [2*NCH-1:0] status,
    output logic             bat_lock
);

    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam int unsigned TW = $clog2(RETRY_CYCLES + 1);

    localparam logic [DW-1:0] DebMax   = DW'(DEBOUNCE);
    localparam logic [TW-1:0] TimMax   = TW'(RETRY_CYCLES);
    localparam logic [TW-1:0] CoolInit = TW'(RETRY_CYCLES - 1);
    localparam logic [3:0]    RetryMax = 4'(MAX_RETRY);

    // Encodings double as the status code driven on the output.
    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StCool = 2'b01,
        StLock = 2'b10,
        StTrip = 2'b11
    } ch_state_e;

    logic          bat_lock_q, bat_lock_d;
    logic [DW-1:0] bdeb_q, bdeb_d;

    always_comb begin
        bat_lock_d = bat_lock_q;
        bdeb_d     = bdeb_q;
        if (bat_lock_q) begin
            bdeb_d = '0;
            if (clear && !over_bat) bat_lock_d = 1'b0;
        end else if (over_bat) begin
            if (bdeb_q != DebMax) bdeb_d = bdeb_q + DW'(1);
            if (bdeb_d == DebMax) bat_lock_d = 1'b1;
        end else begin
            bdeb_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bat_lock_q <= 1'b0;
            bdeb_q     <= '0;
        end else begin
            bat_lock_q <= bat_lock_d;
            bdeb_q     <= bdeb_d;
        end
    end

    assign bat_lock = bat_lock_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e     state_q, state_d;
        logic [DW-1:0] deb_q, deb_d;
        logic [TW-1:0] tim_q, tim_d;   // clean-run timer in RUN, cool-down timer in COOL
        logic [3:0]    cnt_q, cnt_d, cnt_inc;

        always_comb begin
            state_d = state_q;
            deb_d   = deb_q;
            tim_d   = tim_q;
            cnt_d   = cnt_q;
            cnt_inc = (cnt_q == 4'hf) ? 4'hf : cnt_q + 4'd1;
            unique case (state_q)
                StRun: begin
                    if (clear) cnt_d = '0;
                    if (over_ch[i]) begin
                        tim_d = '0;
                        if (deb_q != DebMax) deb_d = deb_q + DW'(1);
                        if (deb_d == DebMax) state_d = StTrip;
                    end else begin
                        deb_d = '0;
                        if (tim_q == TimMax) cnt_d = '0;
                        else                 tim_d = tim_q + TW'(1);
                    end
                end
                StTrip: begin
                    cnt_d = cnt_inc;
                    deb_d = '0;
                    tim_d = '0;
                    if (cnt_inc >= RetryMax) begin
                        state_d = StLock;
                    end else begin
                        state_d = StCool;
                        tim_d   = CoolInit;
                    end
                end
                StCool: begin
                    if (clear) cnt_d = '0;
                    if (tim_q == '0) begin
                        state_d = StRun;
                        deb_d   = '0;
                    end else begin
                        tim_d = tim_q - TW'(1);
                    end
                end
                StLock: begin
                    if (clear && !over_ch[i]) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        deb_d   = '0;
                        tim_d   = '0;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StRun;
                deb_q   <= '0;
                tim_q   <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                tim_q   <= tim_d;
                cnt_q   <= cnt_d;
            end
        end

        assign status[2*i+1:2*i] = state_q;
        assign en[i] = pwm[i] & (state_q == StRun) & ~over_ch[i] & ~bat_lock_q;
    end

endmodule

// File: tb/tb_overcurrent_guard.sv
// Directed bench for overcurrent_guard: blanking, trip/cool timing, lockout, trip-count
// clearing, battery lockout and asynchronous reset.
module tb_overcurrent_guard;

    localparam int unsigned NCH = 2;
    localparam int unsigned DEB = 4;
    localparam int unsigned RC  = 1000;
    localparam int unsigned MR  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] over_ch;
    logic           over_bat;
    logic           clear;
    logic [NCH-1:0] en;
    logic [2*NCH-1:0] status;
    logic           bat_lock;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    overcurrent_guard #(
        .NCH(NCH), .DEBOUNCE(DEB), .RETRY_CYCLES(RC), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .pwm(pwm), .over_ch(over_ch), .over_bat(over_bat),
        .clear(clear), .en(en), .status(status), .bat_lock(bat_lock)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold over_ch[ch] high for DEB cycles; optional clear on the last one.
    task automatic trip_ch(input int ch, input logic clr_last);
        for (int k = 0; k < DEB; k++) begin
            over_ch[ch] = 1'b1;
            if (k == DEB - 1) clear = clr_last;
            step();
        end
        over_ch[ch] = 1'b0;
        clear = 1'b0;
    endtask

    // Count sampled cycles spent in COOL, bounded.
    task automatic wait_cool(input int ch, output int n);
        n = 0;
        while (status[2*ch +: 2] == 2'b01 && n < 1100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pwm = 2'b11; over_ch = 2'b01; over_bat = 1'b0; clear = 1'b0;
        #1;
        total++; if (en !== 2'b10) begin bad++; $display("FAIL reset_en: got %b want 10", en); end
        total++; if (status !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b want 0000", status); end
        total++; if (bat_lock !== 1'b0) begin bad++; $display("FAIL reset_bat: got %b want 0", bat_lock); end
        step(); step();
        reset = 1'b0; over_ch = 2'b00;
        step();
        total++; if (en !== 2'b11) begin bad++; $display("FAIL post_reset_en: got %b want 11", en); end
    endtask

    task automatic test_blank();
        pwm = 2'b11;
        for (int k = 0; k < DEB - 1; k++) begin
            over_ch = 2'b01;
            #1;
            total++; if (en !== 2'b10) begin bad++; $display("FAIL blank_en[%0d]: got %b want 10", k, en); end
            total++; if (status !== 4'b0000) begin bad++; $display("FAIL blank_status[%0d]: got %b want 0000", k, status); end
            step();
        end
        over_ch = 2'b00;
        #1;
        total++; if (en !== 2'b11) begin bad++; $display("FAIL blank_release_en: got %b want 11", en); end
        step(); step();
        total++; if (status !== 4'b0000) begin bad++; $display("FAIL blank_no_trip: got %b want 0000", status); end
    endtask

    task automatic test_trip_cool();
        int n;
        trip_ch(0, 1'b0);
        total++; if (status[1:0] !== 2'b11) begin bad++; $display("FAIL trip_state: got %b want 11", status[1:0]); end
        total++; if (en !== 2'b10) begin bad++; $display("FAIL trip_en: got %b want 10", en); end
        step();
        total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL cool_state: got %b want 01", status[1:0]); end
        total++; if (en[0] !== 1'b0) begin bad++; $display("FAIL cool_en: got %b want 0", en[0]); end
        wait_cool(0, n);
        total++; if (n != 1000) begin bad++; $display("FAIL cool_len: got %0d want 1000", n); end
        total++; if (status !== 4'b0000) begin bad++; $display("FAIL cool_done: got %b want 0000", status); end
        total++; if (en !== 2'b11) begin bad++; $display("FAIL cool_done_en: got %b want 11", en); end
    endtask

    // Count is 1 from the previous trip, so two more trips lock the channel.
    task automatic test_lockout();
        int n;
        trip_ch(0, 1'b0); step();
        total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL lock_trip2: got %b want 01", status[1:0]); end
        wait_cool(0, n);
        trip_ch(0, 1'b0);
        total++; if (status[1:0] !== 2'b11) begin bad++; $display("FAIL lock_trip3: got %b want 11", status[1:0]); end
        step();
        total++; if (status[1:0] !== 2'b10) begin bad++; $display("FAIL lock_state: got %b want 10", status[1:0]); end
        repeat (20) step();
        total++; if (status[1:0] !== 2'b10) begin bad++; $display("FAIL lock_hold: got %b want 10", status[1:0]); end
        total++; if (en !== 2'b10) begin bad++; $display("FAIL lock_en: got %b want 10", en); end
        over_ch = 2'b01; clear = 1'b1; step(); clear = 1'b0; over_ch = 2'b00;
        total++; if (status[1:0] !== 2'b10) begin bad++; $display("FAIL lock_clear_ignored: got %b want 10", status[1:0]); end
        clear = 1'b1; step(); clear = 1'b0;
        total++; if (status[1:0] !== 2'b00) begin bad++; $display("FAIL lock_release: got %b want 00", status[1:0]); end
        total++; if (en !== 2'b11) begin bad++; $display("FAIL lock_release_en: got %b want 11", en); end
    endtask

    task automatic test_count_clear();
        int n;
        for (int t = 0; t < 2; t++) begin
            trip_ch(0, 1'b0); step(); wait_cool(0, n);
        end
        repeat (RC + 10) step();
        for (int t = 0; t < 2; t++) begin
            trip_ch(0, 1'b0); step();
            total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL clean_run_trip%0d: got %b want 01", t, status[1:0]); end
            wait_cool(0, n);
        end
        total++; if (status !== 4'b0000) begin bad++; $display("FAIL clean_run_end: got %b want 0000", status); end
    endtask

    // Count is 2 on entry: clear in RUN zeros it; clear alongside a trip leaves it at 1.
    task automatic test_clear_run();
        int n;
        clear = 1'b1; step(); clear = 1'b0;
        total++; if (status[1:0] !== 2'b00) begin bad++; $display("FAIL clear_run_state: got %b want 00", status[1:0]); end
        for (int t = 0; t < 2; t++) begin
            trip_ch(0, 1'b0); step();
            total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL clear_run_trip%0d: got %b want 01", t, status[1:0]); end
            wait_cool(0, n);
        end
        trip_ch(0, 1'b1);
        total++; if (status[1:0] !== 2'b11) begin bad++; $display("FAIL clear_with_trip: got %b want 11", status[1:0]); end
        step();
        total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL clear_with_trip_cool: got %b want 01", status[1:0]); end
        wait_cool(0, n);
        trip_ch(0, 1'b0); step();
        total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL clear_count2: got %b want 01", status[1:0]); end
        wait_cool(0, n);
        trip_ch(0, 1'b0); step();
        total++; if (status[1:0] !== 2'b10) begin bad++; $display("FAIL clear_count3_lock: got %b want 10", status[1:0]); end
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic test_battery();
        int n;
        pwm = 2'b11; over_ch = 2'b10; over_bat = 1'b1;
        for (int k = 0; k < DEB; k++) begin
            #1;
            total++; if (bat_lock !== 1'b0) begin bad++; $display("FAIL bat_early[%0d]: got %b want 0", k, bat_lock); end
            total++; if (en !== 2'b01) begin bad++; $display("FAIL bat_early_en[%0d]: got %b want 01", k, en); end
            step();
        end
        over_bat = 1'b0; over_ch = 2'b00;
        #1;
        total++; if (bat_lock !== 1'b1) begin bad++; $display("FAIL bat_set: got %b want 1", bat_lock); end
        total++; if (en !== 2'b00) begin bad++; $display("FAIL bat_en: got %b want 00", en); end
        total++; if (status !== 4'b1100) begin bad++; $display("FAIL bat_ch1_trip: got %b want 1100", status); end
        step();
        total++; if (status[3:2] !== 2'b01) begin bad++; $display("FAIL bat_ch1_cool: got %b want 01", status[3:2]); end
        over_bat = 1'b1; clear = 1'b1; step(); clear = 1'b0; over_bat = 1'b0;
        total++; if (bat_lock !== 1'b1) begin bad++; $display("FAIL bat_clear_ignored: got %b want 1", bat_lock); end
        clear = 1'b1; step(); clear = 1'b0;
        total++; if (bat_lock !== 1'b0) begin bad++; $display("FAIL bat_release: got %b want 0", bat_lock); end
        total++; if (en !== 2'b01) begin bad++; $display("FAIL bat_release_en: got %b want 01", en); end
        wait_cool(1, n);
        total++; if (n != 998) begin bad++; $display("FAIL bat_ch1_cool_len: got %0d want 998", n); end
        total++; if (en !== 2'b11) begin bad++; $display("FAIL bat_end_en: got %b want 11", en); end
    endtask

    task automatic test_reset_mid();
        int n;
        trip_ch(0, 1'b0); step();
        total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL rst_pre_cool: got %b want 01", status[1:0]); end
        repeat (10) step();
        reset = 1'b1; #1;
        total++; if (status !== 4'b0000) begin bad++; $display("FAIL rst_mid_cool: got %b want 0000", status); end
        step(); reset = 1'b0;
        for (int t = 0; t < 2; t++) begin
            trip_ch(0, 1'b0); step(); wait_cool(0, n);
        end
        trip_ch(0, 1'b0); step();
        total++; if (status[1:0] !== 2'b10) begin bad++; $display("FAIL rst_pre_lock: got %b want 10", status[1:0]); end
        over_bat = 1'b1; repeat (DEB) step(); over_bat = 1'b0;
        total++; if (bat_lock !== 1'b1) begin bad++; $display("FAIL rst_pre_bat: got %b want 1", bat_lock); end
        reset = 1'b1; #1;
        total++; if (status !== 4'b0000) begin bad++; $display("FAIL rst_mid_lock: got %b want 0000", status); end
        total++; if (bat_lock !== 1'b0) begin bad++; $display("FAIL rst_bat: got %b want 0", bat_lock); end
        total++; if (en !== 2'b11) begin bad++; $display("FAIL rst_en: got %b want 11", en); end
        step(); reset = 1'b0;
        trip_ch(0, 1'b0); step();
        total++; if (status[1:0] !== 2'b01) begin bad++; $display("FAIL rst_single_trip: got %b want 01", status[1:0]); end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_trip_cool();
        test_lockout();
        test_count_clear();
        test_clear_run();
        test_battery();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
